// File: rtl/serial_arith_pkg.sv
// Shared state encoding and width default for the bit-serial arithmetic blocks.
package serial_arith_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus of the serial subtractor.
interface serial_subtractor_if
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, LSB first, one bit per clock.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input logic               clk,
  input logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sh_a_q;
  logic [WIDTH-1:0] sh_b_q;
  logic [WIDTH-1:0] sh_d_q;
  logic [WIDTH-1:0] sh_d_d;
  logic             borrow_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             fs_d;
  logic             fs_bout;
  logic             last_bit;

  full_subtractor u_fs (
    .a    (sh_a_q[0]),
    .b    (sh_b_q[0]),
    .bin  (borrow_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // Right shift with the new difference bit entering at the MSB; written as a
  // concatenate-and-shift so it also holds for WIDTH=1.
  assign sh_d_d   = WIDTH'({fs_d, sh_d_q} >> 1);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // Control FSM plus datapath registers; result registers load only on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      sh_d_q   <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            sh_a_q   <= bus.a;
            sh_b_q   <= bus.b;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          sh_a_q   <= sh_a_q >> 1;
          sh_b_q   <= sh_b_q >> 1;
          sh_d_q   <= sh_d_d;
          borrow_q <= fs_bout;
          cnt_q    <= cnt_q + CW'(1);
          if (last_bit) begin
            diff_q  <= sh_d_d;
            bout_q  <= fs_bout;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy       = (state_q == ST_SHIFT);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor (WIDTH=8 and WIDTH=1) and full_subtractor.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(1)) bus1 ();

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  logic fs_a, fs_b, fs_bin, fs_d, fs_bout;

  full_subtractor u_fs (
    .a    (fs_a),
    .b    (fs_b),
    .bin  (fs_bin),
    .d    (fs_d),
    .bout (fs_bout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One 8-bit operation; optionally hold start high and/or disturb a/b mid-shift.
  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input bit hold_start, input bit disturb);
    logic [7:0] exp_d;
    logic       exp_b;
    logic [7:0] prev_diff;
    int         busy_cyc;
    int         dones;
    bit         held_bad;
    exp_d     = a - b;
    exp_b     = (a < b);
    busy_cyc  = 0;
    dones     = 0;
    held_bad  = 1'b0;
    @(negedge clk);
    prev_diff  = bus8.diff;
    bus8.a     = a;
    bus8.b     = b;
    bus8.start = 1'b1;
    @(negedge clk);
    if (!hold_start) bus8.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus8.busy) busy_cyc++;
      if (bus8.done) dones++;
      if (bus8.diff !== prev_diff) held_bad = 1'b1;
      if (disturb && i == 3) begin
        bus8.a = 8'd99;
        bus8.b = 8'd1;
      end
      @(negedge clk);
    end
    check("busy_cycles", 32'(busy_cyc), 32'd8);
    check("no_early_done", 32'(dones), 32'd0);
    check("diff_held_during_shift", 32'(held_bad), 32'd0);
    check("done_pulse", 32'(bus8.done), 32'd1);
    check("busy_low_in_done", 32'(bus8.busy), 32'd0);
    check("diff", 32'(bus8.diff), 32'(exp_d));
    check("borrow_out", 32'(bus8.borrow_out), 32'(exp_b));
    @(negedge clk);
    check("done_single_cycle", 32'(bus8.done), 32'd0);
    check("idle_after_done", 32'(bus8.busy), 32'd0);
    check("diff_hold_after", 32'(bus8.diff), 32'(exp_d));
    bus8.start = 1'b0;
  endtask

  // One 1-bit operation: a single busy cycle then done.
  task automatic run1(input logic a, input logic b);
    @(negedge clk);
    bus1.a     = a;
    bus1.b     = b;
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    check("w1_busy", 32'(bus1.busy), 32'd1);
    check("w1_no_done_yet", 32'(bus1.done), 32'd0);
    @(negedge clk);
    check("w1_done", 32'(bus1.done), 32'd1);
    check("w1_busy_low", 32'(bus1.busy), 32'd0);
    check("w1_diff", 32'(bus1.diff), 32'((a - b) & 1));
    check("w1_borrow", 32'(bus1.borrow_out), 32'(a < b));
    @(negedge clk);
    check("w1_done_single", 32'(bus1.done), 32'd0);
  endtask

  initial begin
    int dones;
    int r;
    rst_n      = 1'b0;
    bus8.start = 1'b0;
    bus8.a     = '0;
    bus8.b     = '0;
    bus1.start = 1'b0;
    bus1.a     = '0;
    bus1.b     = '0;
    fs_a = 1'b0; fs_b = 1'b0; fs_bin = 1'b0;
    #12;
    check("rst_busy", 32'(bus8.busy), 32'd0);
    check("rst_done", 32'(bus8.done), 32'd0);
    check("rst_diff", 32'(bus8.diff), 32'd0);
    check("rst_borrow", 32'(bus8.borrow_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run8(8'd200, 8'd55, 1'b0, 1'b0);
    run8(8'd5,   8'd10, 1'b0, 1'b0);
    run8(8'd0,   8'd1,  1'b0, 1'b0);
    run8(8'd0,   8'd0,  1'b0, 1'b0);
    run8(8'd200, 8'd55, 1'b1, 1'b1);
    run8(8'd0,   8'd1,  1'b0, 1'b0);

    // Reset asserted in the 4th SHIFT cycle.
    @(negedge clk);
    bus8.a     = 8'd9;
    bus8.b     = 8'd2;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    check("midop_busy_before_rst", 32'(bus8.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midop_rst_busy", 32'(bus8.busy), 32'd0);
    check("midop_rst_done", 32'(bus8.done), 32'd0);
    check("midop_rst_diff", 32'(bus8.diff), 32'd0);
    check("midop_rst_borrow", 32'(bus8.borrow_out), 32'd0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus8.done) dones++;
      if (i == 2) rst_n = 1'b1;
    end
    check("midop_no_done", 32'(dones), 32'd0);
    run8(8'd7, 8'd3, 1'b0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      run8(8'($urandom), 8'($urandom), 1'b0, 1'b0);
    end

    run1(1'b0, 1'b1);
    run1(1'b1, 1'b0);
    run1(1'b1, 1'b1);

    for (int i = 0; i < 8; i++) begin
      {fs_a, fs_b, fs_bin} = 3'(i);
      #10;
      r = int'(fs_a) - int'(fs_b) - int'(fs_bin);
      check("fs_d", 32'(fs_d), 32'(r & 1));
      check("fs_bout", 32'(fs_bout), 32'(r < 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
